// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and
// fixed encodings used by the fetch unit and its program counter.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   // addi x0,x0,0 -- the bubble placed in the decode register
   localparam logic [31:0] NOP                  = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/program_counter.sv
// Fetch PC register with its next-PC mux: redirect beats advance, else hold.
// Redirect targets are word-aligned by clearing the two low bits.
module program_counter
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_advance,
   input  logic        i_redirect,
   input  logic [31:0] i_target,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4
);

   logic [31:0] r_pc;
   logic [31:0] w_pc_next;

   // Natural 32-bit wrap: 0xFFFF_FFFC + 4 is 0 with no carry kept
   assign o_pc_plus4 = r_pc + 32'd4;
   assign o_pc       = r_pc;

   always_comb begin
      w_pc_next = r_pc;
      if (i_redirect)
         w_pc_next = i_target & 32'hFFFF_FFFC;
      else if (i_advance)
         w_pc_next = o_pc_plus4;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_pc <= RESET_VECTOR;
      else
         r_pc <= w_pc_next;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: BOOT/RUN/HALT sequencer, PC and the IF/ID register.
// Control priority in RUN: Halt > PC_Src > Stall_F for the PC; Halt/Flush_D > Stall_F for IF/ID.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter logic [31:0] NOP_INSTR    = NOP
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Stall_F,
   input  logic        Flush_D,
   input  logic        PC_Src,
   input  logic [31:0] PC_Target,
   input  logic        Halt,
   input  logic [31:0] Instr,
   output logic [31:0] PC_Out,
   output logic [31:0] Instr_D,
   output logic [31:0] PC_D,
   output logic [31:0] PC_Plus4_D,
   output logic        Valid_D,
   output logic        Halted,
   output logic [1:0]  o_dbg_state
);

   fetch_state_t r_state;
   fetch_state_t w_state_next;

   logic        w_pc_advance;
   logic        w_pc_redirect;
   logic        w_ifid_load;
   logic        w_ifid_bubble;
   logic [31:0] w_pc_plus4;

   logic [31:0] r_instr_d;
   logic [31:0] r_pc_d;
   logic [31:0] r_pc_plus4_d;
   logic        r_valid_d;

   program_counter #(
      .RESET_VECTOR(RESET_VECTOR)
   ) u_pc (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_advance  (w_pc_advance),
      .i_redirect (w_pc_redirect),
      .i_target   (PC_Target),
      .o_pc       (PC_Out),
      .o_pc_plus4 (w_pc_plus4)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         r_state <= BOOT;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next  = r_state;
      w_pc_advance  = 1'b0;
      w_pc_redirect = 1'b0;
      w_ifid_load   = 1'b0;
      w_ifid_bubble = 1'b0;
      case (r_state)
         BOOT: begin
            w_state_next = RUN;
            w_pc_advance = 1'b1;
            w_ifid_load  = 1'b1;
         end
         RUN: begin
            // Halt wins over a same-cycle redirect; the PC stays put
            if (Halt) begin
               w_state_next  = HALT;
               w_ifid_bubble = 1'b1;
            end else begin
               w_pc_redirect = PC_Src;
               w_pc_advance  = ~Stall_F;
               w_ifid_bubble = Flush_D;
               w_ifid_load   = ~Flush_D & ~Stall_F;
            end
         end
         HALT: begin
            w_state_next = HALT;
         end
         default: begin
            w_state_next = BOOT;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_instr_d    <= NOP_INSTR;
         r_pc_d       <= 32'd0;
         r_pc_plus4_d <= 32'd0;
         r_valid_d    <= 1'b0;
      end else if (w_ifid_bubble) begin
         r_instr_d <= NOP_INSTR;
         r_valid_d <= 1'b0;
      end else if (w_ifid_load) begin
         r_instr_d    <= Instr;
         r_pc_d       <= PC_Out;
         r_pc_plus4_d <= w_pc_plus4;
         r_valid_d    <= 1'b1;
      end
   end

   assign Instr_D     = r_instr_d;
   assign PC_D        = r_pc_d;
   assign PC_Plus4_D  = r_pc_plus4_d;
   assign Valid_D     = r_valid_d;
   assign Halted      = (r_state == HALT);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot sequence, stall, redirect/flush,
// PC wrap, halt and asynchronous reset, against a small instruction memory model.
module tb_fetch_unit;

   logic        CLK;
   logic        RST;
   logic        Stall_F;
   logic        Flush_D;
   logic        PC_Src;
   logic [31:0] PC_Target;
   logic        Halt;
   logic [31:0] Instr;
   logic [31:0] PC_Out;
   logic [31:0] Instr_D;
   logic [31:0] PC_D;
   logic [31:0] PC_Plus4_D;
   logic        Valid_D;
   logic        Halted;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] NOP_W = 32'h0000_0013;

   logic [31:0] prog [0:7] = '{32'h0050_0093, 32'h0010_0113, 32'h0020_8193,
                               32'h0031_0233, 32'h4020_82B3, 32'h0041_2023,
                               32'h0001_2303, 32'hFE00_0EE3};

   // Program occupies 0x00-0x1C; other addresses return a tagged pattern
   function automatic logic [31:0] imem(input logic [31:0] a);
      if (a[31:5] == 27'd0)
         return prog[a[4:2]];
      else
         return {16'hC0DE, a[15:0]};
   endfunction

   assign Instr = imem(PC_Out);

   fetch_unit dut (
      .CLK        (CLK),
      .RST        (RST),
      .Stall_F    (Stall_F),
      .Flush_D    (Flush_D),
      .PC_Src     (PC_Src),
      .PC_Target  (PC_Target),
      .Halt       (Halt),
      .Instr      (Instr),
      .PC_Out     (PC_Out),
      .Instr_D    (Instr_D),
      .PC_D       (PC_D),
      .PC_Plus4_D (PC_Plus4_D),
      .Valid_D    (Valid_D),
      .Halted     (Halted),
      .o_dbg_state(dbg_state)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_ctrl();
      Stall_F = 1'b0; Flush_D = 1'b0; PC_Src = 1'b0; Halt = 1'b0; PC_Target = 32'd0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      clear_ctrl();
      #2;
      checks++; if (PC_Out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", PC_Out, 32'h0); end
      checks++; if (Instr_D !== NOP_W) begin errors++; $display("FAIL reset_instr: got %h exp %h", Instr_D, NOP_W); end
      checks++; if (PC_D !== 32'h0) begin errors++; $display("FAIL reset_pcd: got %h exp %h", PC_D, 32'h0); end
      checks++; if (PC_Plus4_D !== 32'h0) begin errors++; $display("FAIL reset_pc4d: got %h exp %h", PC_Plus4_D, 32'h0); end
      checks++; if (Valid_D !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", Valid_D); end
      checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b exp 0", Halted); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
   endtask

   task automatic test_boot_sequence();
      @(negedge CLK);
      RST = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (PC_Out !== 32'(4 * (k + 1))) begin errors++; $display("FAIL seq_pc[%0d]: got %h exp %h", k, PC_Out, 32'(4 * (k + 1))); end
         checks++; if (PC_D !== 32'(4 * k)) begin errors++; $display("FAIL seq_pcd[%0d]: got %h exp %h", k, PC_D, 32'(4 * k)); end
         checks++; if (PC_Plus4_D !== 32'(4 * k + 4)) begin errors++; $display("FAIL seq_pc4d[%0d]: got %h exp %h", k, PC_Plus4_D, 32'(4 * k + 4)); end
         checks++; if (Instr_D !== imem(32'(4 * k))) begin errors++; $display("FAIL seq_instr[%0d]: got %h exp %h", k, Instr_D, imem(32'(4 * k))); end
         checks++; if (Valid_D !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b exp 1", k, Valid_D); end
      end
   endtask

   task automatic test_stall();
      Stall_F = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (PC_Out !== 32'h10) begin errors++; $display("FAIL stall_pc[%0d]: got %h exp %h", k, PC_Out, 32'h10); end
         checks++; if (PC_D !== 32'h0C) begin errors++; $display("FAIL stall_pcd[%0d]: got %h exp %h", k, PC_D, 32'h0C); end
         checks++; if (Instr_D !== imem(32'h0C)) begin errors++; $display("FAIL stall_instr[%0d]: got %h exp %h", k, Instr_D, imem(32'h0C)); end
         checks++; if (Valid_D !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b exp 1", k, Valid_D); end
      end
      Stall_F = 1'b0;
      tick();
      checks++; if (PC_D !== 32'h10) begin errors++; $display("FAIL unstall_pcd: got %h exp %h", PC_D, 32'h10); end
      checks++; if (Instr_D !== imem(32'h10)) begin errors++; $display("FAIL unstall_instr: got %h exp %h", Instr_D, imem(32'h10)); end
      checks++; if (PC_Out !== 32'h14) begin errors++; $display("FAIL unstall_pc: got %h exp %h", PC_Out, 32'h14); end
   endtask

   task automatic test_redirect_flush();
      PC_Src = 1'b1; PC_Target = 32'h0000_0042; Stall_F = 1'b1; Flush_D = 1'b1;
      tick();
      checks++; if (PC_Out !== 32'h40) begin errors++; $display("FAIL redir_pc: got %h exp %h", PC_Out, 32'h40); end
      checks++; if (Instr_D !== NOP_W) begin errors++; $display("FAIL redir_instr: got %h exp %h", Instr_D, NOP_W); end
      checks++; if (Valid_D !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b exp 0", Valid_D); end
      checks++; if (PC_D !== 32'h10) begin errors++; $display("FAIL redir_pcd_hold: got %h exp %h", PC_D, 32'h10); end
      checks++; if (PC_Plus4_D !== 32'h14) begin errors++; $display("FAIL redir_pc4d_hold: got %h exp %h", PC_Plus4_D, 32'h14); end
      clear_ctrl();
      tick();
      checks++; if (PC_D !== 32'h40) begin errors++; $display("FAIL target_pcd: got %h exp %h", PC_D, 32'h40); end
      checks++; if (Instr_D !== imem(32'h40)) begin errors++; $display("FAIL target_instr: got %h exp %h", Instr_D, imem(32'h40)); end
      checks++; if (Valid_D !== 1'b1) begin errors++; $display("FAIL target_valid: got %b exp 1", Valid_D); end
      checks++; if (PC_Out !== 32'h44) begin errors++; $display("FAIL target_pc: got %h exp %h", PC_Out, 32'h44); end
      Flush_D = 1'b1;
      tick();
      checks++; if (PC_Out !== 32'h48) begin errors++; $display("FAIL flush_pc: got %h exp %h", PC_Out, 32'h48); end
      checks++; if (Instr_D !== NOP_W) begin errors++; $display("FAIL flush_instr: got %h exp %h", Instr_D, NOP_W); end
      checks++; if (Valid_D !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", Valid_D); end
      checks++; if (PC_D !== 32'h40) begin errors++; $display("FAIL flush_pcd_hold: got %h exp %h", PC_D, 32'h40); end
      Flush_D = 1'b0; Stall_F = 1'b1; PC_Src = 1'b1; PC_Target = 32'h0000_0007;
      tick();
      checks++; if (PC_Out !== 32'h04) begin errors++; $display("FAIL stallredir_pc: got %h exp %h", PC_Out, 32'h04); end
      checks++; if (PC_D !== 32'h40) begin errors++; $display("FAIL stallredir_pcd: got %h exp %h", PC_D, 32'h40); end
      checks++; if (Valid_D !== 1'b0) begin errors++; $display("FAIL stallredir_valid: got %b exp 0", Valid_D); end
      clear_ctrl();
      tick();
      checks++; if (PC_D !== 32'h04) begin errors++; $display("FAIL after_redir_pcd: got %h exp %h", PC_D, 32'h04); end
      checks++; if (Instr_D !== imem(32'h04)) begin errors++; $display("FAIL after_redir_instr: got %h exp %h", Instr_D, imem(32'h04)); end
      checks++; if (PC_Out !== 32'h08) begin errors++; $display("FAIL after_redir_pc: got %h exp %h", PC_Out, 32'h08); end
   endtask

   task automatic test_wrap();
      PC_Src = 1'b1; PC_Target = 32'hFFFF_FFFE;
      tick();
      checks++; if (PC_Out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_force_pc: got %h exp %h", PC_Out, 32'hFFFF_FFFC); end
      clear_ctrl();
      tick();
      checks++; if (PC_Out !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h exp %h", PC_Out, 32'h0); end
      checks++; if (PC_Plus4_D !== 32'h0) begin errors++; $display("FAIL wrap_pc4d: got %h exp %h", PC_Plus4_D, 32'h0); end
      checks++; if (PC_D !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pcd: got %h exp %h", PC_D, 32'hFFFF_FFFC); end
      checks++; if (Instr_D !== imem(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_instr: got %h exp %h", Instr_D, imem(32'hFFFF_FFFC)); end
      tick();
      checks++; if (PC_Out !== 32'h04) begin errors++; $display("FAIL post_wrap_pc: got %h exp %h", PC_Out, 32'h04); end
   endtask

   task automatic test_halt();
      Halt = 1'b1; PC_Src = 1'b1; PC_Target = 32'h0000_0080;
      tick();
      checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b exp 1", Halted); end
      checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL halt_state: got %0d exp 2", dbg_state); end
      checks++; if (PC_Out !== 32'h04) begin errors++; $display("FAIL halt_pc: got %h exp %h", PC_Out, 32'h04); end
      checks++; if (Instr_D !== NOP_W) begin errors++; $display("FAIL halt_instr: got %h exp %h", Instr_D, NOP_W); end
      checks++; if (PC_D !== 32'h0) begin errors++; $display("FAIL halt_pcd: got %h exp %h", PC_D, 32'h0); end
      Halt = 1'b0;
      for (int k = 0; k < 10; k++) begin
         PC_Src = k[0]; Stall_F = k[1]; Flush_D = k[2]; PC_Target = 32'(32'h200 + 4 * k);
         tick();
         checks++; if (PC_Out !== 32'h04) begin errors++; $display("FAIL halted_pc[%0d]: got %h exp %h", k, PC_Out, 32'h04); end
         checks++; if (Valid_D !== 1'b0) begin errors++; $display("FAIL halted_valid[%0d]: got %b exp 0", k, Valid_D); end
         checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halted_flag[%0d]: got %b exp 1", k, Halted); end
         checks++; if (Instr_D !== NOP_W) begin errors++; $display("FAIL halted_instr[%0d]: got %h exp %h", k, Instr_D, NOP_W); end
      end
      #2;
      RST = 1'b1;
      #1;
      checks++; if (PC_Out !== 32'h0) begin errors++; $display("FAIL halt_rst_pc: got %h exp %h", PC_Out, 32'h0); end
      checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL halt_rst_flag: got %b exp 0", Halted); end
      clear_ctrl();
      @(negedge CLK);
      RST = 1'b0;
      tick();
      checks++; if (PC_Out !== 32'h04) begin errors++; $display("FAIL reboot_pc: got %h exp %h", PC_Out, 32'h04); end
      checks++; if (PC_D !== 32'h0) begin errors++; $display("FAIL reboot_pcd: got %h exp %h", PC_D, 32'h0); end
      checks++; if (Instr_D !== imem(32'h0)) begin errors++; $display("FAIL reboot_instr: got %h exp %h", Instr_D, imem(32'h0)); end
      checks++; if (Valid_D !== 1'b1) begin errors++; $display("FAIL reboot_valid: got %b exp 1", Valid_D); end
   endtask

   task automatic test_async_reset();
      tick();
      Stall_F = 1'b1;
      tick();
      checks++; if (PC_Out !== 32'h08) begin errors++; $display("FAIL pre_arst_pc: got %h exp %h", PC_Out, 32'h08); end
      #3;
      RST = 1'b1;
      #1;
      checks++; if (PC_Out !== 32'h0) begin errors++; $display("FAIL arst_pc: got %h exp %h", PC_Out, 32'h0); end
      checks++; if (Instr_D !== NOP_W) begin errors++; $display("FAIL arst_instr: got %h exp %h", Instr_D, NOP_W); end
      checks++; if (PC_D !== 32'h0) begin errors++; $display("FAIL arst_pcd: got %h exp %h", PC_D, 32'h0); end
      checks++; if (PC_Plus4_D !== 32'h0) begin errors++; $display("FAIL arst_pc4d: got %h exp %h", PC_Plus4_D, 32'h0); end
      checks++; if (Valid_D !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b exp 0", Valid_D); end
      checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL arst_halted: got %b exp 0", Halted); end
      Stall_F = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      tick();
      checks++; if (PC_Out !== 32'h04) begin errors++; $display("FAIL post_arst_pc: got %h exp %h", PC_Out, 32'h04); end
      checks++; if (Valid_D !== 1'b1) begin errors++; $display("FAIL post_arst_valid: got %b exp 1", Valid_D); end
   endtask

   initial begin
      test_reset();
      test_boot_sequence();
      test_stall();
      test_redirect_flush();
      test_wrap();
      test_halt();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
